dm_port_arbiter: RTL

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one DM port between the CPU M stage and a DMA burst engine.
// Optional macro DM_ARB_FIXED_PRIO_EN: CPU always wins IDLE conflicts instead of round-robin.
//
// state | meaning
// IDLE  | CPU accesses pass through; a DMA request is latched here
// DMA   | one beat per cycle until the latched length is used up
module dm_port_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int DM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_byteen,
  input  logic [31:0] c_pc,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_len,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        d_beat,
  output logic        d_done,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_rdata
);

  localparam logic [3:0]  MAX_LEN   = 4'(MAX_BURST);
  localparam logic [31:0] ADDR_MASK = 32'(DM_WORDS * 4 - 1);

  typedef enum logic {IDLE, DMA} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  beats_q, beats_d;
  logic        we_q, we_d;
  logic        last_dma_q, last_dma_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dma_wins;
  logic        cpu_grant;
  logic        rd_beat;
  logic [3:0]  len_eff;

`ifdef DM_ARB_FIXED_PRIO_EN
  assign dma_wins = 1'b0;
`else
  assign dma_wins = ~last_dma_q;
`endif

  always_comb begin
    if (d_len == 4'd0)         len_eff = 4'd1;
    else if (d_len > MAX_LEN)  len_eff = MAX_LEN;
    else                       len_eff = d_len;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_d       = beats_q;
    we_d          = we_q;
    last_dma_d    = last_dma_q;
    rvalid_d      = 1'b0;
    cpu_grant     = 1'b0;
    rd_beat       = 1'b0;
    c_stall       = 1'b0;
    d_beat        = 1'b0;
    d_done        = 1'b0;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
    m_inst_addr   = 32'h0;
    // While reset is held the port stays quiet and the CPU is not stalled.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (c_req && (!d_req || !dma_wins)) begin
            cpu_grant     = 1'b1;
            m_data_addr   = c_addr;
            m_data_wdata  = c_wdata;
            m_data_byteen = c_byteen;
            m_inst_addr   = c_pc;
            last_dma_d    = 1'b0;
          end else if (d_req) begin
            state_d = DMA;
            addr_d  = d_addr & ~32'h3;
            beats_d = len_eff;
            we_d    = d_we;
            c_stall = c_req;
          end
        end
        DMA: begin
          d_beat        = 1'b1;
          c_stall       = c_req;
          m_data_addr   = addr_q;
          m_data_wdata  = d_wdata;
          m_data_byteen = we_q ? 4'hF : 4'h0;
          addr_d        = (addr_q + 32'd4) & ADDR_MASK;
          rd_beat       = ~we_q;
          rvalid_d      = ~we_q;
          if (beats_q == 4'd1) begin
            d_done     = 1'b1;
            state_d    = IDLE;
            beats_d    = 4'd0;
            last_dma_d = 1'b1;
          end else begin
            beats_d = beats_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read-data paths kept apart from the address mux so m_data_rdata -> output has no false loop.
  assign c_rdata = cpu_grant ? m_data_rdata : 32'h0;
  assign rdata_d = rd_beat ? m_data_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      beats_q    <= 4'd0;
      we_q       <= 1'b0;
      last_dma_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      we_q       <= we_d;
      last_dma_q <= last_dma_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign d_rvalid = rvalid_q;
  assign d_rdata  = rdata_q;

endmodule
